// File: rtl/led_pwm_pkg.sv
`default_nettype none
// led_pwm_pkg -- shared mode encoding and configuration widths for the LED fader.
// Rev 1.0
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam int PERIOD_W = 16;

endpackage
`default_nettype wire

// File: rtl/led_pwm_channel.sv
`default_nettype none
// led_pwm_channel -- per-channel mode/phase state and the wrap-synchronised duty register.
// Rev 1.0
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clki,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_level,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic                tick,
  input  logic                wrap,
  output logic [PWM_BITS-1:0] duty
);

  localparam logic [PWM_BITS-1:0] B_ONE = PWM_BITS'(1);
  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

  mode_t               r_mode,     w_mode;
  logic [PWM_BITS-1:0] r_level,    w_level;
  logic [PERIOD_W-1:0] r_period,   w_period;
  logic [PERIOD_W-1:0] r_tick_cnt, w_tick_cnt;
  logic                r_blink_on, w_blink_on;
  logic [PWM_BITS-1:0] r_bright,   w_bright;
  logic                r_falling,  w_falling;
  logic [PWM_BITS-1:0] r_duty,     w_duty;
  logic [PERIOD_W-1:0] w_last;
  logic [PWM_BITS-1:0] w_level_out;

  // A period of 0 is treated as 1, so the last tick index is 0 in both cases.
  assign w_last = (r_period == '0) ? '0 : r_period - P_ONE;

  always_comb begin
    w_level_out = '0;
    case (r_mode)
      MODE_SOLID:   w_level_out = r_level;
      MODE_BLINK:   w_level_out = r_blink_on ? r_level : '0;
      MODE_BREATHE: w_level_out = r_bright;
      default:      w_level_out = '0;
    endcase
  end

  always_comb begin
    w_mode     = r_mode;
    w_level    = r_level;
    w_period   = r_period;
    w_tick_cnt = r_tick_cnt;
    w_blink_on = r_blink_on;
    w_bright   = r_bright;
    w_falling  = r_falling;
    w_duty     = wrap ? w_level_out : r_duty;

    // A write restarts the phase and swallows a coincident tick.
    if (wr_en) begin
      w_mode     = mode_t'(wr_mode);
      w_level    = wr_level;
      w_period   = wr_period;
      w_tick_cnt = '0;
      w_blink_on = 1'b1;
      w_bright   = '0;
      w_falling  = 1'b0;
    end else if (tick) begin
      if (r_tick_cnt >= w_last) begin
        w_tick_cnt = '0;
        w_blink_on = !r_blink_on;
        if (!r_falling) begin
          if (r_bright < r_level) begin
            w_bright  = r_bright + B_ONE;
            w_falling = ((r_bright + B_ONE) == r_level);
          end else begin
            w_falling = 1'b1;
          end
        end else begin
          if (r_bright != '0) begin
            w_bright  = r_bright - B_ONE;
            w_falling = (r_bright != B_ONE);
          end else begin
            w_falling = 1'b0;
          end
        end
      end else begin
        w_tick_cnt = r_tick_cnt + P_ONE;
      end
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      r_mode     <= MODE_OFF;
      r_level    <= '0;
      r_period   <= '0;
      r_tick_cnt <= '0;
      r_blink_on <= 1'b0;
      r_bright   <= '0;
      r_falling  <= 1'b0;
      r_duty     <= '0;
    end else begin
      r_mode     <= w_mode;
      r_level    <= w_level;
      r_period   <= w_period;
      r_tick_cnt <= w_tick_cnt;
      r_blink_on <= w_blink_on;
      r_bright   <= w_bright;
      r_falling  <= w_falling;
      r_duty     <= w_duty;
    end
  end

  assign duty = r_duty;

endmodule
`default_nettype wire

// File: rtl/led_pwm_fader.sv
`default_nettype none
// led_pwm_fader -- shared timebase prescaler and PWM counter driving NCH fader channels.
// Rev 1.0
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter  int NCH      = 3,
  parameter  int PWM_BITS = 8,
  parameter  int TICK_DIV = 48000,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clki,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_level,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [NCH-1:0]      pwm_out,
  output logic                tick
);

  localparam int               PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]    r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [NCH-1:0]      r_pwm_out;
  logic [NCH-1:0]      w_pwm_next;
  logic                w_wrap;
  logic                w_cfg_ok;
  logic [PWM_BITS-1:0] w_duty [NCH];

  assign tick     = !rst && (r_presc == PRE_LAST);
  assign w_wrap   = (r_pwm_cnt == '1);
  assign w_cfg_ok = cfg_we && (int'(cfg_ch) < NCH);

  always_ff @(posedge clki) begin
    if (rst) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
      r_pwm_out <= '0;
    end else begin
      r_presc   <= (r_presc == PRE_LAST) ? '0 : r_presc + PRE_W'(1);
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_pwm_out <= w_pwm_next;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_channel (
      .clki      (clki),
      .rst       (rst),
      .wr_en     (w_cfg_ok && (cfg_ch == CH_W'(i))),
      .wr_mode   (cfg_mode),
      .wr_level  (cfg_level),
      .wr_period (cfg_period),
      .tick      (tick),
      .wrap      (w_wrap),
      .duty      (w_duty[i])
    );

    assign w_pwm_next[i] = (r_pwm_cnt < w_duty[i]);
  end

  assign pwm_out = r_pwm_out;

endmodule
`default_nettype wire
